// File: rtl/count_enable_gen_pkg.sv
// rtl/count_enable_gen_pkg.sv - shared FSM state type and free-run rate helper
package count_enable_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STEP_HOLD = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int RATE_SEL_W = 2;

  // Terminal divider value: the free-run period is base_div >> rate_sel cycles.
  function automatic int unsigned rate_term(input int unsigned base_div,
                                            input logic [RATE_SEL_W-1:0] rate_sel);
    return (base_div >> rate_sel) - 32'd1;
  endfunction

endpackage

// File: rtl/count_enable_gen_key_debounce.sv
// rtl/count_enable_gen_key_debounce.sv - 2-FF synchroniser, level debouncer and press pulse for an active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_key,
  output logic o_key_db,
  output logic o_press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_accept;

  assign w_diff   = (r_sync2 != r_db);
  // The last mismatching cycle accepts the new level directly, so the counter never holds DEBOUNCE_CYCLES.
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_db    <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_press <= w_accept && !r_sync2;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_key_db    = r_db;
  assign o_press_evt = r_press;

endmodule

// File: rtl/count_enable_gen.sv
// rtl/count_enable_gen.sv - counter enable pulse source: debounced single-step or divided free-run
module count_enable_gen #(
  parameter int BASE_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       step_key,
  input  logic       run_sw,
  input  logic [1:0] rate_sel,
  output logic       tick,
  output logic       running
);

  import count_enable_gen_pkg::*;

  localparam int DIV_W = $clog2(BASE_DIV);

  logic             r_run_sync1;
  logic             r_run_sync2;
  state_e           r_state;
  state_e           w_next_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic [DIV_W-1:0] w_term;
  logic             r_tick;
  logic             w_tick_next;
  logic             r_running;
  logic             w_key_db;
  logic             w_press_evt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .i_key      (step_key),
    .o_key_db   (w_key_db),
    .o_press_evt(w_press_evt)
  );

  // rate_sel is quasi-static and deliberately not synchronised.
  assign w_term = DIV_W'(rate_term(BASE_DIV, rate_sel));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run_sync1 <= 1'b0;
      r_run_sync2 <= 1'b0;
    end else begin
      r_run_sync1 <= run_sw;
      r_run_sync2 <= r_run_sync1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_div_next   = r_div;
    w_tick_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_run_sync2) begin
          w_next_state = ST_RUN;
          w_div_next   = '0;
        end else if (w_press_evt) begin
          w_tick_next  = 1'b1;
          w_next_state = ST_STEP_HOLD;
        end
      end
      ST_STEP_HOLD: begin
        if (w_key_db) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!r_run_sync2) begin
          w_next_state = ST_IDLE;
          w_div_next   = '0;
        end else if (r_div >= w_term) begin
          // >= so a rate change that drops term below the divider fires at once.
          w_tick_next = 1'b1;
          w_div_next  = '0;
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_div_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_div     <= w_div_next;
      r_tick    <= w_tick_next;
      r_running <= (w_next_state == ST_RUN);
    end
  end

  assign tick    = r_tick;
  assign running = r_running;

endmodule

// File: doc/count_enable_gen.md
Name: count_enable_gen

Overview:
- Upstream stage of the 16-bit hex counter/display path: produces the counter's one-cycle `enable` pulse.
- Two modes, both from board inputs:
  - Single-step: a debounced pushbutton press gives exactly one pulse.
  - Free-run: a slide switch gives periodic pulses at one of four selectable rates.
- `tick` connects directly to the counter's enable input.

Parameters:
- BASE_DIV, 50000000, clock cycles per tick at rate_sel=0 (1 Hz at 50 MHz). Must be >=8 and divisible by 8.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz). Must be >=2.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- step_key  in  1  raw pushbutton, asynchronous, active-low (pressed=0)
- run_sw  in  1  raw slide switch, asynchronous; 1 = free-run mode
- rate_sel  in  2  free-run rate: period = BASE_DIV >> rate_sel cycles
- tick  out  1  registered one-cycle enable pulse to the counter
- running  out  1  registered; 1 while FSM is in RUN

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (resetn).
- Values while resetn=0:
  - tick=0, running=0, FSM=IDLE, divider=0, debounce counter=0.
  - key synchroniser and debounced key=1 (released); run synchroniser=0.
- Synchronisers: step_key and run_sw each pass through a 2-FF synchroniser. rate_sel is used unsynchronised (quasi-static).
- Debouncer:
  - Counter increments each cycle that key_sync != key_db and clears on any cycle they are equal.
  - When it reaches DEBOUNCE_CYCLES, key_db takes key_sync and the counter clears.
  - press_evt = 1-cycle pulse when key_db goes 1->0.
  - Release (0->1) is debounced the same way.
- Latency: raw step_key held low -> tick high exactly 2 + DEBOUNCE_CYCLES + 1 rising edges later (FSM in IDLE).
- FSM states: IDLE, STEP_HOLD, RUN.
  - IDLE:
    - run_sync=1 -> RUN, divider=0. Any press_evt in the same cycle is ignored.
    - else press_evt -> tick=1 next cycle, then STEP_HOLD.
  - STEP_HOLD: tick=0; stay until key_db=1, then IDLE. A held key never produces a second tick.
  - RUN:
    - run_sync=0 -> IDLE, divider=0, no tick emitted that cycle.
    - else if divider >= term: tick=1, divider=0.
    - else divider+1.
    - term = (BASE_DIV >> rate_sel) - 1. press_evt is ignored.
- Rate changes:
  - Take effect immediately.
  - If rate_sel lowers term below the current divider, a tick fires on the next edge and the divider restarts.
  - rate_sel=3 with BASE_DIV=8 gives term=0: tick stays high every cycle.
- Leaving RUN with key held: no tick on return to IDLE, because the press is edge-based on key_db.
- Divider width: $clog2(BASE_DIV). Unsigned compare, no wrap beyond term.
- resetn asserted mid-operation: all outputs drop asynchronously. After release, FSM starts in IDLE. Debounced key starts released, so a key held through reset ticks once after debounce.

Decomposition:
- Shared package: FSM state enum (IDLE, STEP_HOLD, RUN) and a rate_sel-to-shift helper constant.
- One sub-module: key_debounce (2-FF sync + debouncer + falling-edge press_evt), parameterised by DEBOUNCE_CYCLES. Reusable for other KEY inputs.

Test Plan (BASE_DIV=8, DEBOUNCE_CYCLES=4):
- Single step: step_key low for 20 cycles then high for 20 -> tick high exactly once, 7 edges after key falls; running=0 throughout.
- Bounce rejection: step_key low 3, high 1, low 2, high 3, repeated 5 times -> no tick. Then held low 10 -> exactly one tick.
- Free-run rates: run_sw=1, rate_sel=0 -> running=1 at 3rd edge; ticks every 8 cycles. rate_sel=2 -> every 2 cycles. rate_sel=3 -> tick constant 1.
- Rate drop mid-count: rate_sel=0, divider reaches 6, set rate_sel=1 -> tick on next edge, then every 4 cycles.
- Simultaneous/priority: run_sw and step_key both asserted so run_sync and press_evt coincide -> RUN entered, no step tick. run_sw=0 with key still low -> IDLE, tick stays 0.
- Async reset: resetn low mid-RUN between edges -> tick=0 and running=0 without a clock edge. Release with keys idle -> IDLE, no tick for 20 cycles.
